// File: rtl/nibble_serial_alu_if.sv
// rtl/nibble_serial_alu_if.sv - operand/result handshake bundle for nibble_serial_alu
interface nibble_serial_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       cmd;
  logic             b_inv;
  logic             carry_in;
  logic             carry_disable;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carry_out;
  logic             zero;
  logic             ones;

  modport master (
    output in_valid, cmd, b_inv, carry_in, carry_disable, d1, d2, out_ready,
    input  in_ready, out_valid, res, carry_out, zero, ones
  );

  modport slave (
    input  in_valid, cmd, b_inv, carry_in, carry_disable, d1, d2, out_ready,
    output in_ready, out_valid, res, carry_out, zero, ones
  );
endinterface

// File: rtl/nibble_serial_alu.sv
// rtl/nibble_serial_alu.sv - WIDTH-bit ALU executed one 4-bit slice per clock, carry chained through a register
module nibble_serial_alu #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  nibble_serial_alu_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] CMD_ADD   = 3'd0;
  localparam logic [2:0] CMD_SUB   = 3'd1;
  localparam logic [2:0] CMD_XOR   = 3'd2;
  localparam logic [2:0] CMD_XNOR  = 3'd3;
  localparam logic [2:0] CMD_AND   = 3'd4;
  localparam logic [2:0] CMD_OR    = 3'd5;
  localparam logic [2:0] CMD_RSHFT = 3'd6;
  localparam logic [2:0] CMD_COMP  = 3'd7;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_alu: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       cmd_q;
  logic             b_inv_q;
  logic             carry_in_q;
  logic             carry_dis_q;
  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] d2_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             chain_q;
  logic             carry_q;
  logic             zero_q;
  logic             ones_q;

  logic             last_nib;
  logic [CW-1:0]    nib_idx;
  logic [CW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_raw;
  logic [3:0]       b_eff;
  logic [3:0]       r_nib;
  logic [4:0]       sum;
  logic             c_in;
  logic             c_out;
  logic [WIDTH-1:0] res_nxt;

  // Carry (or shift-in) a command starts from; also the per-nibble carry when the chain is broken.
  function automatic logic seed_of(input logic [2:0] c, input logic ci);
    case (c)
      CMD_SUB:  seed_of = 1'b1;
      CMD_COMP: seed_of = 1'b0;
      default:  seed_of = ci;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_RUN;
      S_RUN:   if (last_nib) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.res       = res_q;
    bus.carry_out = carry_q;
    bus.zero      = zero_q;
    bus.ones      = ones_q;
  end

  // RSHFT walks MS->LS so the chain can carry each nibble's bit 0 down into the next one.
  always_comb begin
    last_nib = (cnt_q == CW'(NIBBLES - 1));
    nib_idx  = (cmd_q == CMD_RSHFT) ? (CW'(NIBBLES - 1) - cnt_q) : cnt_q;
    base     = {nib_idx, 2'b00};
    a_nib    = d1_q[base +: 4];
    b_raw    = d2_q[base +: 4];
    if (cmd_q == CMD_SUB || cmd_q == CMD_COMP) b_eff = ~b_raw;
    else if (b_inv_q)                          b_eff = ~b_raw;
    else                                       b_eff = b_raw;
    c_in  = carry_dis_q ? seed_of(cmd_q, carry_in_q) : chain_q;
    sum   = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, c_in};
    r_nib = sum[3:0];
    c_out = 1'b0;
    case (cmd_q)
      CMD_ADD, CMD_SUB, CMD_COMP: c_out = sum[4];
      CMD_XOR:   r_nib = a_nib ^ b_eff;
      CMD_XNOR:  r_nib = ~(a_nib ^ b_eff);
      CMD_AND:   r_nib = a_nib & b_eff;
      CMD_OR:    r_nib = a_nib | b_eff;
      CMD_RSHFT: begin
        r_nib = {c_in, b_raw[3:1]};
        c_out = b_raw[0];
      end
      default: r_nib = sum[3:0];
    endcase
    res_nxt             = res_q;
    res_nxt[base +: 4]  = r_nib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= 3'd0;
      b_inv_q     <= 1'b0;
      carry_in_q  <= 1'b0;
      carry_dis_q <= 1'b0;
      d1_q        <= '0;
      d2_q        <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      chain_q     <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cmd_q       <= bus.cmd;
            b_inv_q     <= bus.b_inv;
            carry_in_q  <= bus.carry_in;
            carry_dis_q <= bus.carry_disable;
            d1_q        <= bus.d1;
            d2_q        <= bus.d2;
            cnt_q       <= '0;
            chain_q     <= seed_of(bus.cmd, bus.carry_in);
          end
        end
        S_RUN: begin
          res_q   <= res_nxt;
          chain_q <= c_out;
          cnt_q   <= cnt_q + CW'(1);
          if (last_nib) begin
            carry_q <= c_out;
            zero_q  <= (res_nxt == '0);
            ones_q  <= (&res_nxt);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb/tb_nibble_serial_alu.sv - directed and swept checks of nibble_serial_alu against a width-generic behavioural model
module tb_nibble_serial_alu;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, XNOR = 3'd3;
  localparam logic [2:0] AND = 3'd4, OR = 3'd5, RSHFT = 3'd6, COMP = 3'd7;
  localparam int NIB = 4;

  typedef struct packed {
    logic [63:0] res;
    logic        co;
    logic        z;
    logic        o;
  } exp_t;

  typedef struct {
    logic [2:0]  cmd;
    bit          bi, ci, cd;
    logic [15:0] d1, d2, r;
    bit          co, z, o;
  } dir_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  bit   seen_valid = 0;
  bit   sweep_go = 0;
  exp_t exp_q[$];
  dir_t vec[14];

  nibble_serial_alu_if #(.WIDTH(16)) bus ();
  nibble_serial_alu #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Whole-word arithmetic; a broken chain is the only case that needs per-nibble treatment.
  function automatic exp_t alu_model(input int w, input logic [2:0] c, input bit bi, input bit ci,
                                     input bit cd, input longint unsigned a, input longint unsigned b);
    longint unsigned mask, rep, bb, bn, s, r;
    bit co, cin;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    rep  = mask / 15;
    bb   = (bi ? ~b : b) & mask;
    bn   = (c == ADD) ? bb : (~b & mask);
    cin  = (c == ADD) ? ci : (c == SUB);
    co   = 1'b0;
    r    = 0;
    if (cd && (c == ADD || c == SUB || c == COMP)) begin
      for (int i = 0; i < w / 4; i++) begin
        s  = ((a >> (4 * i)) & 15) + ((bn >> (4 * i)) & 15) + longint'(cin);
        r  = r | ((s & 15) << (4 * i));
        co = ((s >> 4) & 1) != 0;
      end
    end else begin
      case (c)
        ADD:   begin s = a + bb + longint'(ci); r = s; co = ((s >> w) & 1) != 0; end
        SUB:   begin r = a - b; co = (a >= b); end
        COMP:  begin r = a - b - 1; co = (a > b); end
        XOR:   r = a ^ bb;
        XNOR:  r = ~(a ^ bb);
        AND:   r = a & bb;
        OR:    r = a | bb;
        default: begin
          if (cd) r = ((b >> 1) & (rep * 7)) | (ci ? rep * 8 : 0);
          else    r = (b >> 1) | (longint'(ci) << (w - 1));
          co = (b & 1) != 0;
        end
      endcase
    end
    e.res = r & mask;
    e.co  = co;
    e.z   = (e.res == 0);
    e.o   = (e.res == mask);
    return e;
  endfunction

  always @(negedge clk) begin
    edges++;
    if (!rst && bus.out_valid) begin
      if (!seen_valid) begin
        chk("latency_edges", edges, NIB + 1);
        seen_valid = 1'b1;
      end
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        chk("res", bus.res, exp_q[0].res);
        chk("carry_out", bus.carry_out, exp_q[0].co);
        chk("zero", bus.zero, exp_q[0].z);
        chk("ones", bus.ones, exp_q[0].o);
        chk("in_ready_busy", bus.in_ready, 1'b0);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(input dir_t v);
    int n;
    @(negedge clk);
    bus.cmd = v.cmd; bus.b_inv = v.bi; bus.carry_in = v.ci; bus.carry_disable = v.cd;
    bus.d1 = v.d1; bus.d2 = v.d2; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(alu_model(16, v.cmd, v.bi, v.ci, v.cd, 64'(v.d1), 64'(v.d2)));
    #1;
    edges = 0;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 40) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;
    nibble_serial_alu_if #(.WIDTH(W)) sb ();
    nibble_serial_alu #(.WIDTH(W)) sdut (.clk(clk), .rst(rst), .bus(sb));
    logic [W-1:0] a, b;
    logic [2:0]   c;
    bit           bi, ci, cd, done_flag;
    exp_t         e;
    int           n;

    initial begin
      done_flag = 1'b0;
      sb.in_valid = 1'b0; sb.out_ready = 1'b1; sb.cmd = 3'd0; sb.b_inv = 1'b0;
      sb.carry_in = 1'b0; sb.carry_disable = 1'b0; sb.d1 = '0; sb.d2 = '0;
      wait (sweep_go);
      for (int k = 0; k < 40; k++) begin
        c  = 3'($urandom_range(0, 7));
        bi = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        cd = (c == SUB || c == COMP) ? 1'b0 : 1'($urandom_range(0, 1));
        a  = (k % 7 == 0) ? '1 : W'($urandom);
        b  = (k % 5 == 0) ? a : W'($urandom);
        @(negedge clk);
        n = 0;
        while (!sb.in_ready && n < 20) begin @(negedge clk); n++; end
        sb.cmd = c; sb.b_inv = bi; sb.carry_in = ci; sb.carry_disable = cd;
        sb.d1 = a; sb.d2 = b; sb.in_valid = 1'b1;
        @(negedge clk);
        sb.in_valid = 1'b0;
        e = alu_model(W, c, bi, ci, cd, 64'(a), 64'(b));
        n = 0;
        while (!sb.out_valid && n < W / 4 + 4) begin @(negedge clk); n++; end
        chk($sformatf("w%0d_valid", W), sb.out_valid, 1'b1);
        chk($sformatf("w%0d_cmd%0d_res", W, c), sb.res, e.res);
        chk($sformatf("w%0d_cmd%0d_carry", W, c), sb.carry_out, e.co);
        chk($sformatf("w%0d_cmd%0d_zero", W, c), sb.zero, e.z);
        chk($sformatf("w%0d_cmd%0d_ones", W, c), sb.ones, e.o);
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    vec[0]  = '{ADD,   0, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0};
    vec[1]  = '{SUB,   1, 1, 0, 16'h1234, 16'h1235, 16'hFFFF, 0, 0, 1};
    vec[2]  = '{COMP,  0, 0, 0, 16'h8000, 16'h7FFF, 16'h0000, 1, 1, 0};
    vec[3]  = '{COMP,  0, 0, 0, 16'h5A5A, 16'h5A5A, 16'hFFFF, 0, 0, 1};
    vec[4]  = '{RSHFT, 0, 1, 0, 16'h1234, 16'h0003, 16'h8001, 1, 0, 0};
    vec[5]  = '{RSHFT, 0, 1, 1, 16'h1234, 16'h0003, 16'h8889, 1, 0, 0};
    vec[6]  = '{ADD,   0, 0, 1, 16'h0F0F, 16'h0101, 16'h0000, 0, 1, 0};
    vec[7]  = '{ADD,   0, 0, 0, 16'h0F0F, 16'h0101, 16'h1010, 0, 0, 0};
    vec[8]  = '{XNOR,  1, 0, 0, 16'hA5A5, 16'h0FF0, 16'hAA55, 0, 0, 0};
    vec[9]  = '{XOR,   0, 1, 0, 16'h1234, 16'h00FF, 16'h12CB, 0, 0, 0};
    vec[10] = '{AND,   1, 0, 1, 16'hF0F0, 16'h00FF, 16'hF000, 0, 0, 0};
    vec[11] = '{OR,    0, 0, 0, 16'h1200, 16'h0034, 16'h1234, 0, 0, 0};
    vec[12] = '{ADD,   1, 1, 0, 16'h0005, 16'h0003, 16'h0002, 1, 0, 0};
    vec[13] = '{COMP,  0, 0, 0, 16'h0001, 16'h0002, 16'hFFFE, 0, 0, 0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cmd = 3'd0; bus.b_inv = 1'b0;
    bus.carry_in = 1'b0; bus.carry_disable = 1'b0; bus.d1 = '0; bus.d2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_res", bus.res, 16'h0000);
    chk("rst_carry_out", bus.carry_out, 1'b0);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_ones", bus.ones, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      e = alu_model(16, vec[i].cmd, vec[i].bi, vec[i].ci, vec[i].cd, 64'(vec[i].d1), 64'(vec[i].d2));
      chk($sformatf("pin%0d_res", i), e.res, 64'(vec[i].r));
      chk($sformatf("pin%0d_carry", i), e.co, vec[i].co);
      chk($sformatf("pin%0d_zero", i), e.z, vec[i].z);
      chk($sformatf("pin%0d_ones", i), e.o, vec[i].o);
    end

    for (int i = 0; i < 14; i++) begin
      if (i != 8) begin
        issue(vec[i]);
        wait_idle();
      end
    end

    // Stall in DONE while a competing operation is offered.
    bus.out_ready = 1'b0;
    issue(vec[8]);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_reach_done", bus.out_valid, 1'b1);
    bus.cmd = ADD; bus.d1 = 16'hDEAD; bus.d2 = 16'hBEEF; bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1'b1);
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_queue", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_op", bus.in_ready, 1'b1);
    end

    issue(vec[0]);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_res", bus.res, 16'h0000);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_carry_out", bus.carry_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    issue(vec[7]);
    wait_idle();

    sweep_go = 1'b1;
    n = 0;
    while (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_complete", g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
